// File: rtl/base64_encoder_if.sv
// Pixel-in / character-out handshake bundle for the base64 return-path encoder.
// The encoder takes the slave side; upstream memory and the UART TX take the master side.
interface base64_encoder_if;
    logic [2:0] pixel_data;
    logic       pixel_valid;
    logic       pixel_last;
    logic       pixel_ready;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;

    modport slave (
        input  pixel_data,
        input  pixel_valid,
        input  pixel_last,
        input  tx_data_ready,
        output pixel_ready,
        output tx_data,
        output tx_data_valid
    );

    modport master (
        output pixel_data,
        output pixel_valid,
        output pixel_last,
        output tx_data_ready,
        input  pixel_ready,
        input  tx_data,
        input  tx_data_valid
    );
endinterface

// File: rtl/base64_encoder.sv
// Packs pairs of 3-bit pixels into sextets and sends one base64 ASCII character per sextet,
// with optional newline at frame end and every LINE_CHARS characters.
module base64_encoder #(
    parameter int EMIT_NEWLINE = 1,
    parameter int LINE_CHARS   = 0
) (
    input  logic              clk,
    input  logic              rst,
    base64_encoder_if.slave   enc,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE_HI   = 2'd0,
        WAIT_LO   = 2'd1,
        SEND_CHAR = 2'd2,
        SEND_NL   = 2'd3
    } state_t;

    localparam logic       EMIT_NL    = (EMIT_NEWLINE != 0);
    localparam logic       LINE_EN    = (LINE_CHARS != 0);
    localparam logic [8:0] LINE_LIMIT = 9'(LINE_CHARS);

    state_t     state_r, state_s;
    logic [5:0] sextet_r, sextet_s;
    logic [7:0] line_cnt_r, line_cnt_s;
    logic       last_r, last_s;
    logic       pixel_ready_r, pixel_ready_s;
    logic       tx_valid_r, tx_valid_s;
    logic [7:0] tx_data_r, tx_data_s;
    logic       busy_r, busy_s;
    logic       pix_xfer_s;
    logic       char_xfer_s;
    logic       line_hit_s;
    logic       need_nl_s;

    function automatic logic [7:0] b64_char(input logic [5:0] v);
        logic [7:0] c;
        if (v <= 6'd25) begin
            c = 8'h41 + {2'b00, v};
        end else if (v <= 6'd51) begin
            c = 8'h61 + ({2'b00, v} - 8'd26);
        end else if (v <= 6'd61) begin
            c = 8'h30 + ({2'b00, v} - 8'd52);
        end else if (v == 6'd62) begin
            c = 8'h2B;
        end else begin
            c = 8'h2F;
        end
        return c;
    endfunction

    assign pix_xfer_s  = enc.pixel_valid && pixel_ready_r;
    assign char_xfer_s = tx_valid_r && enc.tx_data_ready;
    assign line_hit_s  = LINE_EN && (({1'b0, line_cnt_r} + 9'd1) == LINE_LIMIT);
    // A frame ending exactly on a line boundary still yields a single newline.
    assign need_nl_s   = (last_r && EMIT_NL) || line_hit_s;

    // Next-state and datapath updates
    always_comb begin
        state_s    = state_r;
        sextet_s   = sextet_r;
        line_cnt_s = line_cnt_r;
        last_s     = last_r;
        case (state_r)
            IDLE_HI: begin
                if (pix_xfer_s) begin
                    sextet_s = {enc.pixel_data, 3'b000};
                    if (enc.pixel_last) begin
                        last_s  = 1'b1;
                        state_s = SEND_CHAR;
                    end else begin
                        state_s = WAIT_LO;
                    end
                end else begin
                    state_s = IDLE_HI;
                end
            end
            WAIT_LO: begin
                if (pix_xfer_s) begin
                    sextet_s = {sextet_r[5:3], enc.pixel_data};
                    last_s   = enc.pixel_last;
                    state_s  = SEND_CHAR;
                end else begin
                    state_s = WAIT_LO;
                end
            end
            SEND_CHAR: begin
                if (char_xfer_s) begin
                    if (need_nl_s) begin
                        line_cnt_s = line_cnt_r + 8'd1;
                        state_s    = SEND_NL;
                    end else if (last_r) begin
                        line_cnt_s = 8'd0;
                        last_s     = 1'b0;
                        state_s    = IDLE_HI;
                    end else begin
                        line_cnt_s = line_cnt_r + 8'd1;
                        state_s    = IDLE_HI;
                    end
                end else begin
                    state_s = SEND_CHAR;
                end
            end
            SEND_NL: begin
                if (char_xfer_s) begin
                    line_cnt_s = 8'd0;
                    last_s     = 1'b0;
                    state_s    = IDLE_HI;
                end else begin
                    state_s = SEND_NL;
                end
            end
            default: begin
                state_s = IDLE_HI;
            end
        endcase
    end

    // Output values derived from the upcoming state so every output leaves a flop
    always_comb begin
        pixel_ready_s = (state_s == IDLE_HI) || (state_s == WAIT_LO);
        tx_valid_s    = (state_s == SEND_CHAR) || (state_s == SEND_NL);
        busy_s        = (state_s != IDLE_HI);
        if (state_s == SEND_NL) begin
            tx_data_s = 8'h0A;
        end else if (state_s == SEND_CHAR) begin
            tx_data_s = b64_char(sextet_s);
        end else begin
            tx_data_s = 8'h00;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE_HI;
            sextet_r      <= 6'd0;
            line_cnt_r    <= 8'd0;
            last_r        <= 1'b0;
            pixel_ready_r <= 1'b0;
            tx_valid_r    <= 1'b0;
            tx_data_r     <= 8'h00;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            sextet_r      <= sextet_s;
            line_cnt_r    <= line_cnt_s;
            last_r        <= last_s;
            pixel_ready_r <= pixel_ready_s;
            tx_valid_r    <= tx_valid_s;
            tx_data_r     <= tx_data_s;
            busy_r        <= busy_s;
        end
    end

    assign enc.pixel_ready   = pixel_ready_r;
    assign enc.tx_data_valid = tx_valid_r;
    assign enc.tx_data       = tx_data_r;
    assign busy              = busy_r;

endmodule

// File: tb/tb_base64_encoder.sv
// Scoreboard bench for base64_encoder: three instances with different newline settings,
// an independent character model feeding expected queues, directed and random stimulus.
module tb_base64_encoder;

    localparam int          NDUT  = 3;
    localparam logic [2:0]  EN_NL = 3'b011;
    localparam logic [23:0] LCS   = {8'd3, 8'd2, 8'd0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] pd  [NDUT];
    logic       pv  [NDUT];
    logic       pl  [NDUT];
    logic       txr [NDUT];
    logic       rdy [NDUT];
    logic       vld [NDUT];
    logic       bsy [NDUT];
    logic [7:0] txd [NDUT];

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    logic [7:0] exp_q2[$];
    logic       have_hi [NDUT];
    logic [2:0] hi      [NDUT];
    int         cnt     [NDUT];
    bit         rnd_bp = 1'b0;
    string      b64 = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789+/";

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int q_size(input int k);
        if (k == 0) return exp_q0.size();
        else if (k == 1) return exp_q1.size();
        else return exp_q2.size();
    endfunction

    task automatic q_push(input int k, input logic [7:0] c);
        if (k == 0) exp_q0.push_back(c);
        else if (k == 1) exp_q1.push_back(c);
        else exp_q2.push_back(c);
    endtask

    task automatic q_pop(input int k, output logic [7:0] c);
        if (k == 0) c = exp_q0.pop_front();
        else if (k == 1) c = exp_q1.pop_front();
        else c = exp_q2.pop_front();
    endtask

    task automatic model_reset();
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        for (int k = 0; k < NDUT; k++) begin
            have_hi[k] = 1'b0;
            hi[k]      = 3'd0;
            cnt[k]     = 0;
        end
    endtask

    task automatic model_emit(input int k, input logic [5:0] v, input logic last);
        logic [7:0] c;
        int         lc;
        bit         nl;
        c  = b64[int'(v)];
        lc = int'(LCS[k*8 +: 8]);
        q_push(k, c);
        cnt[k]++;
        nl = (last && EN_NL[k]) || (lc != 0 && cnt[k] == lc);
        if (nl) q_push(k, 8'h0A);
        if (nl || last) cnt[k] = 0;
    endtask

    task automatic model_pix(input int k, input logic [2:0] d, input logic last);
        if (!have_hi[k]) begin
            if (last) model_emit(k, {d, 3'b000}, 1'b1);
            else begin
                have_hi[k] = 1'b1;
                hi[k]      = d;
            end
        end else begin
            have_hi[k] = 1'b0;
            model_emit(k, {hi[k], d}, last);
        end
    endtask

    task automatic send_pix(input int k, input logic [2:0] d, input logic last);
        bit ok;
        model_pix(k, d, last);
        @(negedge clk);
        pd[k] = d;
        pl[k] = last;
        pv[k] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rdy[k]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_eq("pixel_accept_timeout", 32'(rdy[k]), 32'd1);
        else begin
            @(posedge clk);
            #1;
        end
        pv[k] = 1'b0;
        pl[k] = 1'b0;
    endtask

    task automatic mon(input int k);
        logic [7:0] e;
        if (!rst && vld[k] && txr[k]) begin
            if (q_size(k) == 0) begin
                check_eq($sformatf("spurious_char_dut%0d", k), 32'(txd[k]), 32'hFFFF_FFFF);
            end else begin
                q_pop(k, e);
                check_eq($sformatf("char_dut%0d", k), 32'(txd[k]), 32'(e));
            end
        end
    endtask

    task automatic drain();
        int left;
        left = 0;
        for (int i = 0; i < 1000; i++) begin
            left = q_size(0) + q_size(1) + q_size(2);
            if (left == 0) break;
            @(negedge clk);
        end
        check_eq("drain_empty", 32'(left), 32'd0);
        @(negedge clk);
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : gd
        base64_encoder_if bif ();
        assign bif.pixel_data    = pd[g];
        assign bif.pixel_valid   = pv[g];
        assign bif.pixel_last    = pl[g];
        assign bif.tx_data_ready = txr[g];
        assign rdy[g]            = bif.pixel_ready;
        assign vld[g]            = bif.tx_data_valid;
        assign txd[g]            = bif.tx_data;

        base64_encoder #(
            .EMIT_NEWLINE (int'(EN_NL[g])),
            .LINE_CHARS   (int'(LCS[g*8 +: 8]))
        ) u_dut (
            .clk  (clk),
            .rst  (rst),
            .enc  (bif.slave),
            .busy (bsy[g])
        );

        always @(negedge clk) mon(g);
    end

    // Random backpressure, changed away from the sampling edge
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rnd_bp) begin
                for (int k = 0; k < NDUT; k++) txr[k] = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            pd[k] = 3'd0; pv[k] = 1'b0; pl[k] = 1'b0; txr[k] = 1'b1;
        end
        model_reset();
        repeat (3) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check_eq("rst_pixel_ready", 32'(rdy[k]), 32'd0);
            check_eq("rst_tx_valid", 32'(vld[k]), 32'd0);
            check_eq("rst_tx_data", 32'(txd[k]), 32'h00);
            check_eq("rst_busy", 32'(bsy[k]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) check_eq("ready_after_rst", 32'(rdy[k]), 32'd1);

        // Pixels 0,0 -> 'A' one cycle after the second accept
        send_pix(0, 3'd0, 1'b0);
        check_eq("wait_lo_no_valid", 32'(vld[0]), 32'd0);
        send_pix(0, 3'd0, 1'b0);
        check_eq("lat_valid", 32'(vld[0]), 32'd1);
        check_eq("lat_data", 32'(txd[0]), 32'h41);
        check_eq("ready_in_send", 32'(rdy[0]), 32'd0);
        check_eq("busy_in_send", 32'(bsy[0]), 32'd1);

        // Mid-alphabet, digit and the two special characters, no frame end
        send_pix(0, 3'd3, 1'b0); send_pix(0, 3'd4, 1'b0);
        send_pix(0, 3'd7, 1'b0); send_pix(0, 3'd6, 1'b0);
        send_pix(0, 3'd7, 1'b0); send_pix(0, 3'd7, 1'b0);
        send_pix(0, 3'd6, 1'b0); send_pix(0, 3'd7, 1'b0);
        drain();

        // Odd trailing pixel with last -> zero-filled char then newline
        send_pix(0, 3'd5, 1'b1);
        drain();
        check_eq("idle_busy", 32'(bsy[0]), 32'd0);
        check_eq("idle_ready", 32'(rdy[0]), 32'd1);

        // Backpressure: char held stable for 5 cycles
        txr[0] = 1'b0;
        send_pix(0, 3'd1, 1'b0);
        send_pix(0, 3'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_valid", 32'(vld[0]), 32'd1);
            check_eq("stall_data", 32'(txd[0]), 32'h4B);
            check_eq("stall_ready", 32'(rdy[0]), 32'd0);
        end
        txr[0] = 1'b1;
        drain();

        // LINE_CHARS=2: coincident frame end and line boundary, then counter restart
        send_pix(1, 3'd1, 1'b0); send_pix(1, 3'd2, 1'b0);
        send_pix(1, 3'd3, 1'b0); send_pix(1, 3'd4, 1'b1);
        send_pix(1, 3'd5, 1'b0); send_pix(1, 3'd6, 1'b0);
        send_pix(1, 3'd7, 1'b0); send_pix(1, 3'd0, 1'b0);
        send_pix(1, 3'd1, 1'b0); send_pix(1, 3'd1, 1'b1);
        // No frame newline, but frame end still clears the line count
        send_pix(2, 3'd1, 1'b0); send_pix(2, 3'd1, 1'b0);
        send_pix(2, 3'd2, 1'b1);
        for (int i = 0; i < 6; i++) send_pix(2, 3'(i), 1'b0);
        drain();

        // Random pixels under random backpressure on every instance
        rnd_bp = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 30; i++) begin
                send_pix(k, 3'($urandom_range(0, 7)), (i == 29) || ($urandom_range(0, 5) == 0));
            end
        end
        rnd_bp = 1'b0;
        for (int k = 0; k < NDUT; k++) txr[k] = 1'b1;
        drain();

        // Reset while a char is stalled
        txr[0] = 1'b0;
        send_pix(0, 3'd4, 1'b0);
        send_pix(0, 3'd5, 1'b0);
        check_eq("pre_rst_valid", 32'(vld[0]), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_eq("midrst_valid", 32'(vld[0]), 32'd0);
        check_eq("midrst_data", 32'(txd[0]), 32'h00);
        check_eq("midrst_busy", 32'(bsy[0]), 32'd0);
        @(negedge clk);
        check_eq("midrst_ready", 32'(rdy[0]), 32'd0);
        rst = 1'b0;
        txr[0] = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_ready", 32'(rdy[0]), 32'd1);
        send_pix(0, 3'd2, 1'b0);
        send_pix(0, 3'd3, 1'b0);
        check_eq("post_rst_char", 32'(txd[0]), 32'h54);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
